// File: rtl/spi_boot_loader_if.sv
// SPI pad-side signals and instruction-memory write port of the boot loader.
interface spi_boot_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_ss;
  logic              spi_miso;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output spi_sck, spi_mosi, spi_ss, imem_we, imem_addr, imem_wdata,
    input  spi_miso
  );

  modport slave (
    input  spi_sck, spi_mosi, spi_ss, imem_we, imem_addr, imem_wdata,
    output spi_miso
  );
endinterface

// File: rtl/spi_boot_loader.sv
// Boot-time SPI flash reader: one READ (0x03) copies BOOT_WORDS words into imem.
// Define KMIE_BOOT_CHECKSUM_EN to read and verify a trailing image checksum word.
module spi_boot_loader #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned BOOT_WORDS = 1024,
  parameter int unsigned ADDR_W     = 10,
  parameter logic [23:0] FLASH_BASE = 24'h000000
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_boot_loader_if.master bus,
  output logic              boot_sequence_done,
  output logic              boot_error
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [31:0] HDR   = {8'h03, FLASH_BASE};

  typedef enum logic [3:0] {
    StIdle, StCsSetup, StCmd, StAddr, StData, StCsum, StCsHold, StDone, StError
  } state_e;

  state_e            state_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [4:0]        bit_cnt_q;
  logic [ADDR_W-1:0] word_cnt_q;
  logic [30:0]       hdr_q;
  logic [30:0]       word_q;
  logic [31:0]       word_next;
  logic [31:0]       word_le;
  logic              div_done;
  logic              last_word;

`ifdef KMIE_BOOT_CHECKSUM_EN
  logic [31:0] csum_q;
  logic        csum_bad_q;
  logic        error_q;
  assign boot_error = error_q;
`else
  assign boot_error = 1'b0;
`endif

  // Bytes arrive MSB-first; the first byte of a word lands in bits [7:0].
  always_comb begin
    word_next = {word_q, bus.spi_miso};
    word_le   = {word_next[7:0], word_next[15:8], word_next[23:16], word_next[31:24]};
    div_done  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    last_word = (word_cnt_q == ADDR_W'(BOOT_WORDS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= StIdle;
      div_cnt_q          <= '0;
      bit_cnt_q          <= '0;
      word_cnt_q         <= '0;
      hdr_q              <= '0;
      word_q             <= '0;
      bus.spi_ss         <= 1'b1;
      bus.spi_sck        <= 1'b0;
      bus.spi_mosi       <= 1'b0;
      bus.imem_we        <= 1'b0;
      bus.imem_addr      <= '0;
      bus.imem_wdata     <= '0;
      boot_sequence_done <= 1'b0;
`ifdef KMIE_BOOT_CHECKSUM_EN
      csum_q             <= '0;
      csum_bad_q         <= 1'b0;
      error_q            <= 1'b0;
`endif
    end else begin
      bus.imem_we <= 1'b0;
      unique case (state_q)
        StIdle: begin
          bus.spi_ss   <= 1'b0;
          bus.spi_mosi <= HDR[31];
          hdr_q        <= HDR[30:0];
          state_q      <= StCsSetup;
        end
        StCsSetup: begin
          div_cnt_q <= div_done ? '0 : div_cnt_q + DIV_W'(1);
          if (div_done) state_q <= StCmd;
        end
        StCmd, StAddr, StData, StCsum: begin
          div_cnt_q <= div_done ? '0 : div_cnt_q + DIV_W'(1);
          if (div_done && !bus.spi_sck) begin
            // SCK rises: this is the MISO sampling cycle.
            bus.spi_sck <= 1'b1;
            word_q      <= word_next[30:0];
            if (state_q == StData && bit_cnt_q == 5'd31) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_cnt_q;
              bus.imem_wdata <= word_le;
`ifdef KMIE_BOOT_CHECKSUM_EN
              csum_q         <= csum_q + word_le;
`endif
            end
`ifdef KMIE_BOOT_CHECKSUM_EN
            if (state_q == StCsum && bit_cnt_q == 5'd31) csum_bad_q <= (word_le != csum_q);
`endif
          end else if (div_done) begin
            // SCK falls: MOSI advances with it; the header drains to zeros for DATA.
            bus.spi_sck  <= 1'b0;
            bus.spi_mosi <= hdr_q[30];
            hdr_q        <= {hdr_q[29:0], 1'b0};
            bit_cnt_q    <= bit_cnt_q + 5'd1;
            if (state_q == StCmd && bit_cnt_q == 5'd7) begin
              state_q <= StAddr;
            end else if (bit_cnt_q == 5'd31) begin
              if (state_q == StAddr) begin
                state_q <= StData;
              end else if (state_q == StData) begin
                word_cnt_q <= word_cnt_q + ADDR_W'(1);
`ifdef KMIE_BOOT_CHECKSUM_EN
                if (last_word) state_q <= StCsum;
`else
                if (last_word) state_q <= StCsHold;
`endif
              end else if (state_q == StCsum) begin
                state_q <= StCsHold;
              end
            end
          end
        end
        StCsHold: begin
          bus.spi_ss <= 1'b1;
`ifdef KMIE_BOOT_CHECKSUM_EN
          if (csum_bad_q) begin
            error_q <= 1'b1;
            state_q <= StError;
          end else begin
            boot_sequence_done <= 1'b1;
            state_q            <= StDone;
          end
`else
          boot_sequence_done <= 1'b1;
          state_q            <= StDone;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
